// File: rtl/tracker_sequencer_if.sv
// Bus between the tracker sequencer, the ADC front end and the servo drivers.
// master: host/ADC side driving requests and samples; slave: the sequencer.
interface tracker_sequencer_if #(
  parameter int unsigned DATA_W = 12
);
  logic              start;
  logic              abort;
  logic              sample_valid;
  logic [DATA_W-1:0] ldr_a;
  logic [DATA_W-1:0] ldr_b;
  logic [DATA_W-1:0] ldr_c;
  logic [DATA_W-1:0] ldr_d;
  logic [1:0]        frame_dir;
  logic [1:0]        panel_dir;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        state;

  modport master (
    output start, abort, sample_valid, ldr_a, ldr_b, ldr_c, ldr_d,
    input  frame_dir, panel_dir, busy, done, err, state
  );

  modport slave (
    input  start, abort, sample_valid, ldr_a, ldr_b, ldr_c, ldr_d,
    output frame_dir, panel_dir, busy, done, err, state
  );
endinterface

// File: rtl/tracker_sequencer.sv
// Sun-tracking sequencer: aligns the frame (azimuth) axis, then the panel
// (elevation) axis, by timed move/settle steps driven from LDR pair differences.
// Optional macro AUTO_RETRACK_EN: restart tracking after RETRACK_CYC idle cycles
// once at least one tracking cycle has completed.
module tracker_sequencer #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned DEADBAND    = 16,
  parameter int unsigned MOVE_CYC    = 1000000,
  parameter int unsigned SETTLE_CYC  = 5000000,
  parameter int unsigned MAX_STEPS   = 255,
  parameter int unsigned RETRACK_CYC = 500000000
) (
  input logic                clk,
  input logic                rst,
  tracker_sequencer_if.slave bus
);

  localparam int unsigned DIFF_W  = DATA_W + 1;
  localparam int unsigned CYC_MAX = (MOVE_CYC > SETTLE_CYC) ? MOVE_CYC : SETTLE_CYC;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
  localparam int unsigned STEP_W  = $clog2(MAX_STEPS + 1);

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_CW   = 2'b01;
  localparam logic [1:0] DIR_CCW  = 2'b10;

  localparam logic signed [DIFF_W-1:0] DB_POS = DIFF_W'(DEADBAND);
  localparam logic signed [DIFF_W-1:0] DB_NEG = -DB_POS;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMP_F = 3'd1,
    S_MOVE_F = 3'd2,
    S_SETL_F = 3'd3,
    S_SAMP_P = 3'd4,
    S_MOVE_P = 3'd5,
    S_SETL_P = 3'd6,
    S_FIN    = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [1:0]         code_q, code_d;
  logic               err_q, err_d;
  logic [1:0]         frame_dir_q, frame_dir_d;
  logic [1:0]         panel_dir_q, panel_dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               retrack_go;

  logic signed [DIFF_W-1:0] diff_f, diff_p, diff_sel;

  // Signed sensor differences; one extra bit makes overflow impossible.
  assign diff_f   = $signed({1'b0, bus.ldr_a}) - $signed({1'b0, bus.ldr_b});
  assign diff_p   = $signed({1'b0, bus.ldr_c}) - $signed({1'b0, bus.ldr_d});
  assign diff_sel = (state_q == S_SAMP_P) ? diff_p : diff_f;

`ifdef AUTO_RETRACK_EN
  localparam int unsigned RT_W = $clog2(RETRACK_CYC + 1);

  logic [RT_W-1:0] idle_cnt_q;
  logic            armed_q;

  // Idle timer, armed by the first completed tracking cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      if (state_q == S_FIN) armed_q <= 1'b1;
      if (bus.start || bus.abort || retrack_go || state_q != S_IDLE) begin
        idle_cnt_q <= '0;
      end else if (armed_q) begin
        idle_cnt_q <= idle_cnt_q + RT_W'(1);
      end
    end
  end

  assign retrack_go = armed_q && (state_q == S_IDLE) &&
                      (idle_cnt_q == RT_W'(RETRACK_CYC - 1));
`else
  logic unused_retrack;
  assign retrack_go     = 1'b0;
  assign unused_retrack = ^RETRACK_CYC;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      step_q      <= '0;
      code_q      <= DIR_STOP;
      err_q       <= 1'b0;
      frame_dir_q <= DIR_STOP;
      panel_dir_q <= DIR_STOP;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      step_q      <= step_d;
      code_q      <= code_d;
      err_q       <= err_d;
      frame_dir_q <= frame_dir_d;
      panel_dir_q <= panel_dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state sequencing and next output values.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    step_d  = step_q;
    code_d  = code_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start || retrack_go) begin
          state_d = S_SAMP_F;
          cyc_d   = '0;
          step_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_SAMP_F, S_SAMP_P: begin
        if (bus.sample_valid) begin
          if (diff_sel > DB_POS || diff_sel < DB_NEG) begin
            state_d = (state_q == S_SAMP_F) ? S_MOVE_F : S_MOVE_P;
            code_d  = (diff_sel > DB_POS) ? DIR_CW : DIR_CCW;
            cyc_d   = '0;
            step_d  = step_q + STEP_W'(1);
          end else if (state_q == S_SAMP_F) begin
            state_d = S_SAMP_P;
            step_d  = '0;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_MOVE_F, S_MOVE_P: begin
        if (cyc_q == CYC_W'(MOVE_CYC - 1)) begin
          cyc_d   = '0;
          state_d = (state_q == S_MOVE_F) ? S_SETL_F : S_SETL_P;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_SETL_F, S_SETL_P: begin
        if (cyc_q == CYC_W'(SETTLE_CYC - 1)) begin
          cyc_d = '0;
          if (step_q == STEP_W'(MAX_STEPS)) begin
            err_d = 1'b1;
            if (state_q == S_SETL_F) begin
              state_d = S_SAMP_P;
              step_d  = '0;
            end else begin
              state_d = S_FIN;
            end
          end else begin
            state_d = (state_q == S_SETL_F) ? S_SAMP_F : S_SAMP_P;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.abort) begin
      state_d = S_IDLE;
      cyc_d   = '0;
    end

    frame_dir_d = (state_d == S_MOVE_F) ? code_d : DIR_STOP;
    panel_dir_d = (state_d == S_MOVE_P) ? code_d : DIR_STOP;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FIN);
  end

  assign bus.frame_dir = frame_dir_q;
  assign bus.panel_dir = panel_dir_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_tracker_sequencer.sv
// Directed self-checking bench for tracker_sequencer with short timing parameters.
module tb_tracker_sequencer;

  localparam int unsigned DATA_W      = 12;
  localparam int unsigned DEADBAND    = 16;
  localparam int unsigned MOVE_CYC    = 4;
  localparam int unsigned SETTLE_CYC  = 3;
  localparam int unsigned MAX_STEPS   = 3;
  localparam int unsigned RETRACK_CYC = 20;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SAMP_F = 3'd1;
  localparam logic [2:0] S_MOVE_F = 3'd2;
  localparam logic [2:0] S_SETL_F = 3'd3;
  localparam logic [2:0] S_SAMP_P = 3'd4;
  localparam logic [2:0] S_MOVE_P = 3'd5;
  localparam logic [2:0] S_SETL_P = 3'd6;
  localparam logic [2:0] S_FIN    = 3'd7;

  logic clk;
  logic rst;

  tracker_sequencer_if #(.DATA_W(DATA_W)) ifc ();

  tracker_sequencer #(
    .DATA_W     (DATA_W),
    .DEADBAND   (DEADBAND),
    .MOVE_CYC   (MOVE_CYC),
    .SETTLE_CYC (SETTLE_CYC),
    .MAX_STEPS  (MAX_STEPS),
    .RETRACK_CYC(RETRACK_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int inv_viol   = 0;
  int done_cnt   = 0;
  int ccw_pulses = 0;
  int panel_nz   = 0;
  logic [1:0] prev_panel = 2'b00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running observation of output invariants and pulse counts.
  always @(negedge clk) begin
    if (ifc.frame_dir == 2'b11 || ifc.panel_dir == 2'b11 ||
        (ifc.frame_dir != 2'b00 && ifc.panel_dir != 2'b00)) inv_viol++;
    if (ifc.done === 1'b1) done_cnt++;
    if (ifc.panel_dir == 2'b10 && prev_panel != 2'b10) ccw_pulses++;
    if (ifc.panel_dir != 2'b00) panel_nz++;
    prev_panel = ifc.panel_dir;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ldr(input int unsigned a, input int unsigned b,
                         input int unsigned c, input int unsigned d);
    ifc.ldr_a = DATA_W'(a);
    ifc.ldr_b = DATA_W'(b);
    ifc.ldr_c = DATA_W'(c);
    ifc.ldr_d = DATA_W'(d);
  endtask

  task automatic do_start();
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
  endtask

  task automatic give_sample();
    ifc.sample_valid = 1'b1;
    tick();
    ifc.sample_valid = 1'b0;
  endtask

  task automatic do_abort();
    ifc.abort = 1'b1;
    tick();
    ifc.abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    ifc.sample_valid = 1'b0;
    set_ldr(0, 0, 0, 0);
    repeat (3) tick();
    n_checks++; if (ifc.state !== S_IDLE) $display("FAIL reset_state: got %0d want %0d", ifc.state, S_IDLE); else n_pass++;
    n_checks++; if ({ifc.frame_dir, ifc.panel_dir} !== 4'b0000) $display("FAIL reset_dirs: got %b want 0000", {ifc.frame_dir, ifc.panel_dir}); else n_pass++;
    n_checks++; if ({ifc.busy, ifc.done, ifc.err} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {ifc.busy, ifc.done, ifc.err}); else n_pass++;
    rst = 1'b0;
    tick();
    // Reset asserted in the middle of a frame move.
    set_ldr(1000, 900, 700, 700);
    do_start();
    give_sample();
    tick();
    n_checks++; if (ifc.frame_dir !== 2'b01) $display("FAIL premove_dir: got %b want 01", ifc.frame_dir); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (ifc.frame_dir !== 2'b00) $display("FAIL async_rst_dir: got %b want 00", ifc.frame_dir); else n_pass++;
    n_checks++; if ({ifc.busy, ifc.err} !== 2'b00) $display("FAIL async_rst_flags: got %b want 00", {ifc.busy, ifc.err}); else n_pass++;
    n_checks++; if (ifc.state !== S_IDLE) $display("FAIL async_rst_state: got %0d want %0d", ifc.state, S_IDLE); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if (ifc.state !== S_IDLE) $display("FAIL post_rst_state: got %0d want %0d", ifc.state, S_IDLE); else n_pass++;
  endtask

  task automatic test_single_step();
    int done0;
    int pnz0;
    done0 = done_cnt;
    pnz0  = panel_nz;
    set_ldr(1000, 900, 700, 700);
    do_start();
    n_checks++; if ({ifc.state, ifc.busy} !== {S_SAMP_F, 1'b1}) $display("FAIL start_samp_f: got %0d/%b want %0d/1", ifc.state, ifc.busy, S_SAMP_F); else n_pass++;
    give_sample();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (ifc.frame_dir !== 2'b01) $display("FAIL move_hold_%0d: got %b want 01", i, ifc.frame_dir); else n_pass++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({ifc.state, ifc.frame_dir} !== {S_SETL_F, 2'b00}) $display("FAIL settle_%0d: got %0d/%b want %0d/00", i, ifc.state, ifc.frame_dir, S_SETL_F); else n_pass++;
      tick();
    end
    n_checks++; if (ifc.state !== S_SAMP_F) $display("FAIL resample_f: got %0d want %0d", ifc.state, S_SAMP_F); else n_pass++;
    set_ldr(500, 500, 700, 700);
    ifc.sample_valid = 1'b1;
    tick();
    n_checks++; if (ifc.state !== S_SAMP_P) $display("FAIL frame_aligned: got %0d want %0d", ifc.state, S_SAMP_P); else n_pass++;
    tick();
    ifc.sample_valid = 1'b0;
    n_checks++; if ({ifc.state, ifc.done, ifc.busy} !== {S_FIN, 2'b11}) $display("FAIL fin_done: got %0d/%b%b want %0d/11", ifc.state, ifc.done, ifc.busy, S_FIN); else n_pass++;
    tick();
    n_checks++; if ({ifc.state, ifc.done, ifc.busy} !== {S_IDLE, 2'b00}) $display("FAIL fin_to_idle: got %0d/%b%b want %0d/00", ifc.state, ifc.done, ifc.busy, S_IDLE); else n_pass++;
    n_checks++; if (done_cnt - done0 !== 1) $display("FAIL single_done_count: got %0d want 1", done_cnt - done0); else n_pass++;
    n_checks++; if (panel_nz - pnz0 !== 0) $display("FAIL panel_quiet: got %0d want 0", panel_nz - pnz0); else n_pass++;
  endtask

  task automatic test_deadband();
    // C-D = +16 is aligned.
    set_ldr(500, 500, 716, 700);
    do_start();
    ifc.sample_valid = 1'b1;
    tick();
    tick();
    ifc.sample_valid = 1'b0;
    n_checks++; if ({ifc.state, ifc.panel_dir} !== {S_FIN, 2'b00}) $display("FAIL db_plus16: got %0d/%b want %0d/00", ifc.state, ifc.panel_dir, S_FIN); else n_pass++;
    tick();
    // C-D = -17 moves the panel ccw.
    set_ldr(500, 500, 700, 717);
    do_start();
    ifc.sample_valid = 1'b1;
    tick();
    tick();
    ifc.sample_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({ifc.state, ifc.panel_dir} !== {S_MOVE_P, 2'b10}) $display("FAIL db_minus17_%0d: got %0d/%b want %0d/10", i, ifc.state, ifc.panel_dir, S_MOVE_P); else n_pass++;
      tick();
    end
    n_checks++; if ({ifc.state, ifc.panel_dir} !== {S_SETL_P, 2'b00}) $display("FAIL db_panel_settle: got %0d/%b want %0d/00", ifc.state, ifc.panel_dir, S_SETL_P); else n_pass++;
    repeat (3) tick();
    n_checks++; if (ifc.state !== S_SAMP_P) $display("FAIL db_resample_p: got %0d want %0d", ifc.state, S_SAMP_P); else n_pass++;
    set_ldr(500, 500, 700, 700);
    give_sample();
    n_checks++; if (ifc.state !== S_FIN) $display("FAIL db_panel_fin: got %0d want %0d", ifc.state, S_FIN); else n_pass++;
    tick();
    // A-B = +17 moves the frame cw.
    set_ldr(517, 500, 700, 700);
    do_start();
    give_sample();
    n_checks++; if ({ifc.state, ifc.frame_dir} !== {S_MOVE_F, 2'b01}) $display("FAIL db_plus17: got %0d/%b want %0d/01", ifc.state, ifc.frame_dir, S_MOVE_F); else n_pass++;
    do_abort();
    n_checks++; if (ifc.state !== S_IDLE) $display("FAIL db_abort_idle: got %0d want %0d", ifc.state, S_IDLE); else n_pass++;
  endtask

  task automatic test_step_limit();
    int done0;
    int ccw0;
    done0 = done_cnt;
    ccw0  = ccw_pulses;
    set_ldr(500, 500, 100, 900);
    do_start();
    ifc.sample_valid = 1'b1;
    for (int i = 0; i < 80 && ifc.state !== S_FIN; i++) tick();
    ifc.sample_valid = 1'b0;
    n_checks++; if (ifc.state !== S_FIN) $display("FAIL limit_reach_fin: got %0d want %0d", ifc.state, S_FIN); else n_pass++;
    n_checks++; if ({ifc.err, ifc.done} !== 2'b11) $display("FAIL limit_err_done: got %b want 11", {ifc.err, ifc.done}); else n_pass++;
    n_checks++; if (ccw_pulses - ccw0 !== 3) $display("FAIL limit_pulses: got %0d want 3", ccw_pulses - ccw0); else n_pass++;
    tick();
    n_checks++; if ({ifc.state, ifc.err} !== {S_IDLE, 1'b1}) $display("FAIL limit_err_sticky: got %0d/%b want %0d/1", ifc.state, ifc.err, S_IDLE); else n_pass++;
    repeat (3) tick();
    do_abort();
    n_checks++; if (ifc.err !== 1'b1) $display("FAIL abort_keeps_err: got %b want 1", ifc.err); else n_pass++;
    n_checks++; if (done_cnt - done0 !== 1) $display("FAIL limit_done_count: got %0d want 1", done_cnt - done0); else n_pass++;
    do_start();
    n_checks++; if ({ifc.state, ifc.err} !== {S_SAMP_F, 1'b0}) $display("FAIL start_clears_err: got %0d/%b want %0d/0", ifc.state, ifc.err, S_SAMP_F); else n_pass++;
    do_abort();
  endtask

  task automatic test_abort_ignore();
    int done0;
    done0 = done_cnt;
    set_ldr(1000, 900, 700, 700);
    do_start();
    give_sample();
    // START and an aligned sample during MOVE_F must be ignored.
    set_ldr(500, 500, 700, 700);
    ifc.start = 1'b1;
    ifc.sample_valid = 1'b1;
    tick();
    ifc.start = 1'b0;
    ifc.sample_valid = 1'b0;
    n_checks++; if ({ifc.state, ifc.frame_dir} !== {S_MOVE_F, 2'b01}) $display("FAIL ignore_in_move: got %0d/%b want %0d/01", ifc.state, ifc.frame_dir, S_MOVE_F); else n_pass++;
    repeat (2) tick();
    n_checks++; if (ifc.frame_dir !== 2'b01) $display("FAIL ignore_move_c4: got %b want 01", ifc.frame_dir); else n_pass++;
    tick();
    n_checks++; if ({ifc.state, ifc.frame_dir} !== {S_SETL_F, 2'b00}) $display("FAIL ignore_move_len: got %0d/%b want %0d/00", ifc.state, ifc.frame_dir, S_SETL_F); else n_pass++;
    repeat (3) tick();
    n_checks++; if (ifc.state !== S_SAMP_F) $display("FAIL ignore_resample: got %0d want %0d", ifc.state, S_SAMP_F); else n_pass++;
    // Abort on the second MOVE_F cycle, with START also high.
    set_ldr(1000, 900, 700, 700);
    give_sample();
    tick();
    ifc.abort = 1'b1;
    ifc.start = 1'b1;
    tick();
    ifc.abort = 1'b0;
    ifc.start = 1'b0;
    n_checks++; if ({ifc.state, ifc.frame_dir, ifc.busy} !== {S_IDLE, 2'b00, 1'b0}) $display("FAIL abort_move: got %0d/%b/%b want %0d/00/0", ifc.state, ifc.frame_dir, ifc.busy, S_IDLE); else n_pass++;
    n_checks++; if (done_cnt - done0 !== 0) $display("FAIL abort_no_done: got %0d want 0", done_cnt - done0); else n_pass++;
    // ABORT wins over START in IDLE.
    ifc.abort = 1'b1;
    ifc.start = 1'b1;
    tick();
    ifc.abort = 1'b0;
    ifc.start = 1'b0;
    n_checks++; if ({ifc.state, ifc.busy} !== {S_IDLE, 1'b0}) $display("FAIL abort_over_start: got %0d/%b want %0d/0", ifc.state, ifc.busy, S_IDLE); else n_pass++;
  endtask

  task automatic test_retrack();
    set_ldr(500, 500, 700, 700);
    do_start();
    ifc.sample_valid = 1'b1;
    tick();
    tick();
    ifc.sample_valid = 1'b0;
    n_checks++; if (ifc.state !== S_FIN) $display("FAIL retrack_setup_fin: got %0d want %0d", ifc.state, S_FIN); else n_pass++;
    tick();
    repeat (19) tick();
    n_checks++; if (ifc.busy !== 1'b0) $display("FAIL retrack_early: got %b want 0", ifc.busy); else n_pass++;
    tick();
`ifdef AUTO_RETRACK_EN
    n_checks++; if ({ifc.state, ifc.busy} !== {S_SAMP_F, 1'b1}) $display("FAIL retrack_start: got %0d/%b want %0d/1", ifc.state, ifc.busy, S_SAMP_F); else n_pass++;
    do_abort();
`else
    n_checks++; if (ifc.busy !== 1'b0) $display("FAIL no_retrack: got %b want 0", ifc.busy); else n_pass++;
    repeat (10) tick();
    n_checks++; if (ifc.busy !== 1'b0) $display("FAIL no_retrack_late: got %b want 0", ifc.busy); else n_pass++;
`endif
  endtask

  task automatic test_invariants();
    n_checks++; if (inv_viol !== 0) $display("FAIL dir_invariants: got %0d violations want 0", inv_viol); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_deadband();
    test_step_limit();
    test_abort_ignore();
    test_retrack();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
